wptr_full: RTL

Write-domain pointer and full-flag generator for the asynchronous FIFO.
- Consumes the read pointer after it has been brought into the write clock domain (two-flop Gray-coded synchronizer output `wq2_rptr`).
- Produces the RAM write address, the Gray write pointer for the read-side synchronizer, a registered full flag, a fill level, an optional almost-full flag, and a sticky overflow flag.
- Sits between the write-side client and the dual-port RAM / write-to-read synchronizer.

---
 rtl/wptr_full.sv | 84 ++++++++
 1 files changed

// File: rtl/wptr_full.sv
// Write-side pointer, full flag and fill level for an asynchronous FIFO.
// Optional almost-full comparator enabled by defining WPTR_FULL_ALMOST_EN.
module wptr_full #(
  parameter int addr_width   = 8,
  parameter int afull_thresh = 2**addr_width - 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [addr_width:0]   wq2_rptr,
  output logic [addr_width-1:0] waddr,
  output logic [addr_width:0]   wptr,
  output logic                  wfull,
  output logic [addr_width:0]   wlevel,
  output logic                  walmost_full,
  output logic                  woverflow
);

  localparam int aw = addr_width;

  if (addr_width < 2 || afull_thresh < 0 || afull_thresh > 2**addr_width) begin : g_param_check
    $error("wptr_full: addr_width must be >= 2 and afull_thresh within 0..2**addr_width");
  end

  logic [aw:0] wbin;
  logic [aw:0] wbinnext;
  logic [aw:0] wgraynext;
  logic [aw:0] rbin_s;
  logic [aw:0] level_next;
  logic [aw:0] full_ptr;
  logic        wpush;

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= aw; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign wpush      = winc & ~wfull;
  assign wbinnext   = wbin + {{aw{1'b0}}, wpush};
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign level_next = wbinnext - rbin_s;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_ptr   = {~wq2_rptr[aw:aw-1], wq2_rptr[aw-2:0]};
  assign waddr      = wbin[aw-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= (wgraynext == full_ptr);
      wlevel <= level_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end
    end
  end

`ifdef WPTR_FULL_ALMOST_EN
  localparam logic [aw:0] afull_lvl = (aw + 1)'(afull_thresh);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (level_next >= afull_lvl);
    end
  end
`else
  assign walmost_full = 1'b0;
`endif

endmodule
